// File: rtl/decoder_pkg.sv
// Shared types and widths for the 3-to-8 strobe decoder.
package decoder_pkg;

    localparam int unsigned CODE_W   = 3;
    localparam int unsigned ONEHOT_W = 8;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StGap
    } state_e;

    function automatic logic [ONEHOT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
        logic [ONEHOT_W-1:0] oh;
        oh       = '0;
        oh[code] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/dec_hold_counter.sv
// Hold-time down-counter: load, decrement toward zero (saturating), zero detect.
module dec_hold_counter
    import decoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_3to8_strobe.sv
// 3-to-8 one-hot strobe decoder holding each output for HOLD_CYCLES cycles.
// Define DECODER_BREAK_BEFORE_MAKE_EN to insert a gap cycle between strobes.
module decoder_3to8_strobe
    import decoder_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   in3,
    output logic [ONEHOT_W-1:0] out8,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] LoadVal = CNT_W'(HOLD_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [ONEHOT_W-1:0] out8_q, out8_d;
    logic                cnt_zero;
    logic                accept;

    dec_hold_counter u_hold_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (LoadVal),
        .zero     (cnt_zero)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            StIdle:  in_ready = 1'b1;
`ifndef DECODER_BREAK_BEFORE_MAKE_EN
            StHold:  in_ready = cnt_zero;
`endif
            default: in_ready = 1'b0;
        endcase
        if (rst) begin
            in_ready = 1'b0;
        end
    end

    assign accept = in_valid & in_ready;

    // out8 is registered from the decode of the code being captured, giving latency 1.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        out8_d  = out8_q;
        if (accept) begin
            state_d = StHold;
            code_d  = in3;
            out8_d  = decode_onehot(code_d);
        end else begin
            case (state_q)
                StHold: begin
                    if (cnt_zero) begin
`ifdef DECODER_BREAK_BEFORE_MAKE_EN
                        state_d = StGap;
`else
                        state_d = StIdle;
`endif
                        out8_d  = '0;
                    end
                end
                StGap: begin
                    state_d = StIdle;
                    out8_d  = '0;
                end
                default: begin
                    out8_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            code_q  <= '0;
            out8_q  <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            out8_q  <= out8_d;
        end
    end

    assign out8 = out8_q;
    assign busy = (state_q != StIdle);
    assign done = (state_q == StHold) && cnt_zero && !rst;

endmodule
